agent_router: RTL and testbench



---
 rtl/agent_router_pkg.sv | 34 +++
 rtl/agent_fifo.sv | 66 ++++++
 rtl/agent_router.sv | 199 +++++++++++++++++++
 tb/tb_agent_router.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agent_router_pkg.sv
// agent_router shared types: header layout, ALU op codes, ids.
// Imported by the router top and its FIFO.
package agent_router_pkg;

  localparam int HDR_W   = 32;
  localparam int DST_LSB = 24;
  localparam int SRC_LSB = 16;
  localparam int OP_LSB  = 12;
  localparam int TAG_LSB = 0;

  localparam logic [7:0] BROADCAST_ID = 8'hFF;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_XOR = 4'h3,
    OP_MUL = 4'h4,
    OP_ERR = 4'hF
  } op_e;

  typedef struct packed {
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [3:0]  op;
    logic [11:0] tag;
  } hdr_t;

  typedef enum logic {
    PRI_RES = 1'b0,
    PRI_BYP = 1'b1
  } pri_e;

endpackage

// File: rtl/agent_fifo.sv
// Synchronous FIFO, power-of-2 depth, push accepted on full when popping.
// Registered count drives empty/full.
module agent_fifo
  import agent_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   vldin,
  input  logic                   readout,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  assign push = vldin && (!full || readout);
  assign pop  = readout && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    unique case (1'b1)
      (push && !pop): cnt_d = cnt_q + CW'(1);
      (pop && !push): cnt_d = cnt_q - CW'(1);
      default:        cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/agent_router.sv
// Mesh agent node: local messages run through an ALU pipeline and
// return to the sender; all others bypass; round-robin merge out.
module agent_router
  import agent_router_pkg::*;
#(
  parameter  int DATA_W    = 64,
  parameter  int IN_DEPTH  = 4,
  parameter  int OUT_DEPTH = 4,
  parameter  int LAT       = 2,
  localparam int MSG_W     = 32 + 2 * DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       localid,
  input  logic             en,
  input  logic [MSG_W-1:0] msgin,
  output logic             okin,
  output logic [MSG_W-1:0] msgout,
  input  logic             okout,
  output logic             busy,
  output logic [15:0]      drop_cnt
);

  localparam int IW = $clog2(IN_DEPTH) + 1;
  localparam int OW = $clog2(OUT_DEPTH) + 1;

  logic             in_vld, in_push, in_pop;
  logic [MSG_W-1:0] in_dout;
  logic             in_empty, in_full;
  logic [IW-1:0]    in_cnt;

  logic             byp_push, byp_pop;
  logic [MSG_W-1:0] byp_dout;
  logic             byp_empty, byp_full;
  logic [OW-1:0]    byp_cnt;

  logic             res_push, res_pop;
  logic [MSG_W-1:0] res_dout;
  logic             res_empty, res_full;
  logic [OW-1:0]    res_cnt;

  logic [15:0]      drop_q, drop_d;
  pri_e             prio_q, prio_d;

  logic [MSG_W-1:0] pipe_q [LAT];
  logic [LAT-1:0]   pv_q, pv_d;

  hdr_t             hh;
  logic             is_local, issue, credit_ok;
  logic [OW:0]      inflight, used;
  logic [DATA_W-1:0] aa, bb, result;
  logic [3:0]       rop;
  logic [MSG_W-1:0] resp;
  logic             sel_res, sel_byp;

  // Entry: okin follows the registered full flag only.
  assign in_vld  = (msgin[HDR_W-1:0] != '0);
  assign okin    = !in_full;
  assign in_push = in_vld && !in_full;

  agent_fifo #(.WIDTH(MSG_W), .DEPTH(IN_DEPTH)) u_in (
    .clk     (clk),
    .rst     (rst),
    .din     (msgin),
    .vldin   (in_push),
    .readout (in_pop),
    .dout    (in_dout),
    .empty   (in_empty),
    .full    (in_full),
    .count   (in_cnt)
  );

  assign hh = hdr_t'(in_dout[HDR_W-1:0]);
  assign aa = in_dout[HDR_W +: DATA_W];
  assign bb = in_dout[HDR_W+DATA_W +: DATA_W];

  assign is_local = (hh.dst == localid) && (hh.dst != BROADCAST_ID);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++)
      inflight = inflight + (OW+1)'(pv_q[i]);
  end

  assign used      = {1'b0, res_cnt} + inflight;
  assign credit_ok = (used < (OW+1)'(OUT_DEPTH));

  assign issue    = !in_empty && is_local && en && credit_ok;
  assign byp_push = !in_empty && !is_local && !byp_full;
  assign in_pop   = issue || byp_push;

  always_comb begin
    result = '0;
    rop    = hh.op;
    unique case (1'b1)
      (hh.op == OP_ADD): result = aa + bb;
      (hh.op == OP_SUB): result = aa - bb;
      (hh.op == OP_AND): result = aa & bb;
      (hh.op == OP_XOR): result = aa ^ bb;
      (hh.op == OP_MUL): result = aa * bb;
      default: begin
        result = '0;
        rop    = OP_ERR;
      end
    endcase
  end

  assign resp = {~result, result, hh.src, localid, rop, hh.tag};

  always_comb begin
    pv_d = pv_q;
    if (en) begin
      pv_d[0] = issue;
      for (int i = 1; i < LAT; i++)
        pv_d[i] = pv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pv_q <= '0;
    else     pv_q <= pv_d;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      pipe_q[0] <= resp;
      for (int i = 1; i < LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Credits keep res_full low here; the guard only protects contents.
  assign res_push = en && pv_q[LAT-1] && !res_full;

  agent_fifo #(.WIDTH(MSG_W), .DEPTH(OUT_DEPTH)) u_res (
    .clk     (clk),
    .rst     (rst),
    .din     (pipe_q[LAT-1]),
    .vldin   (res_push),
    .readout (res_pop),
    .dout    (res_dout),
    .empty   (res_empty),
    .full    (res_full),
    .count   (res_cnt)
  );

  agent_fifo #(.WIDTH(MSG_W), .DEPTH(OUT_DEPTH)) u_byp (
    .clk     (clk),
    .rst     (rst),
    .din     (in_dout),
    .vldin   (byp_push),
    .readout (byp_pop),
    .dout    (byp_dout),
    .empty   (byp_empty),
    .full    (byp_full),
    .count   (byp_cnt)
  );

  assign sel_res = !res_empty && (byp_empty || prio_q == PRI_RES);
  assign sel_byp = !byp_empty && !sel_res;
  assign res_pop = okout && sel_res;
  assign byp_pop = okout && sel_byp;

  always_comb begin
    msgout = '0;
    unique case (1'b1)
      sel_res: msgout = res_dout;
      sel_byp: msgout = byp_dout;
      default: msgout = '0;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (res_pop || byp_pop)
      prio_d = (prio_q == PRI_RES) ? PRI_BYP : PRI_RES;
  end

  always_comb begin
    drop_d = drop_q;
    if (in_vld && in_full && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PRI_RES;
      drop_q <= '0;
    end else begin
      prio_q <= prio_d;
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
  assign busy     = (in_cnt != '0) || (byp_cnt != '0)
                 || (res_cnt != '0) || (|pv_q);

endmodule

// File: tb/tb_agent_router.sv
// Scoreboard bench for agent_router: expected messages are queued
// at drive time and matched as msgout is accepted.
module tb_agent_router;

  localparam int MSG_W = 160;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       lid;
  logic             en;
  logic [MSG_W-1:0] msgin;
  logic             okin;
  logic [MSG_W-1:0] msgout;
  logic             okout;
  logic             busy;
  logic [15:0]      drop_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [MSG_W-1:0] res_q [$];
  logic [MSG_W-1:0] byp_q [$];
  bit               kinds [$];
  logic [MSG_W-1:0] mon_e;

  agent_router dut (
    .clk      (clk),
    .rst      (rst),
    .localid  (lid),
    .en       (en),
    .msgin    (msgin),
    .okin     (okin),
    .msgout   (msgout),
    .okout    (okout),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [MSG_W-1:0] got,
                     input logic [MSG_W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk(
    input logic [7:0] d, input logic [7:0] s,
    input logic [3:0] op, input logic [11:0] tag,
    input logic [63:0] a, input logic [63:0] b);
    return {b, a, d, s, op, tag};
  endfunction

  function automatic logic [MSG_W-1:0] exp_resp(
    input logic [MSG_W-1:0] m);
    logic [63:0] a, b, r;
    logic [3:0]  op;
    a  = m[95:32];
    b  = m[159:96];
    op = m[15:12];
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a ^ b;
      4'h4: r = a * b;
      default: begin
        r  = 64'd0;
        op = 4'hF;
      end
    endcase
    return {~r, r, m[23:16], lid, op, m[11:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && okout && msgout != '0) begin
      if (msgout[23:16] == lid) begin
        kinds.push_back(1'b0);
        if (res_q.size() == 0) chk("res_unexp", msgout, '0);
        else begin
          mon_e = res_q.pop_front();
          chk("res", msgout, mon_e);
        end
      end else begin
        kinds.push_back(1'b1);
        if (byp_q.size() == 0) chk("byp_unexp", msgout, '0);
        else begin
          mon_e = byp_q.pop_front();
          chk("byp", msgout, mon_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || res_q.size() != 0 || byp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("idle", MSG_W'(busy), '0);
    chk("drain", MSG_W'(res_q.size() + byp_q.size()), '0);
  endtask

  task automatic do_reset();
    res_q.delete();
    byp_q.delete();
    msgin = '0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    @(negedge clk);
    chk("rst_busy", MSG_W'(busy), '0);
    chk("rst_msgout", msgout, '0);
    chk("rst_drop", MSG_W'(drop_cnt), '0);
    chk("rst_okin", MSG_W'(okin), MSG_W'(1));
    step();
    kinds.delete();
  endtask

  task automatic lat_run(input logic [MSG_W-1:0] m, input bit stall,
                         output int cyc);
    msgin = m;
    cyc   = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) msgin = '0;
      if (stall) en = !(cyc >= 2 && cyc <= 6);
      @(negedge clk);
    end while (msgout == '0 && cyc < 60);
    en = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [MSG_W-1:0] m, m1, m2, b1, b2;
    logic [7:0]       d;
    logic [3:0]       ord;
    int               cyc;

    rst   = 1'b1;
    en    = 1'b1;
    okout = 1'b1;
    lid   = 8'h05;
    msgin = '0;
    repeat (2) step();
    @(negedge clk);
    chk("init_msgout", msgout, '0);
    chk("init_okin", MSG_W'(okin), MSG_W'(1));
    chk("init_busy", MSG_W'(busy), '0);
    chk("init_drop", MSG_W'(drop_cnt), '0);
    step();
    rst = 1'b0;
    step();

    // local add: 3 + 4 back to the sender
    m = mk(8'h05, 8'h09, 4'h0, 12'h001, 64'd3, 64'd4);
    res_q.push_back(exp_resp(m));
    lat_run(m, 1'b0, cyc);
    chk("lat_local", MSG_W'(cyc), MSG_W'(4));
    wait_idle();

    // foreign destination passes untouched
    m = mk(8'h22, 8'h09, 4'h2, 12'h0A5, {$urandom, $urandom}, {$urandom, $urandom});
    byp_q.push_back(m);
    lat_run(m, 1'b0, cyc);
    chk("lat_byp", MSG_W'(cyc), MSG_W'(2));
    wait_idle();

    // unknown op becomes an error response
    m = mk(8'h05, 8'h09, 4'h7, 12'h3C3, 64'd11, 64'd12);
    res_q.push_back(exp_resp(m));
    msgin = m;
    step();
    msgin = '0;
    wait_idle();

    // mixed traffic incl. broadcast
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0:       d = lid;
        1:       d = 8'h22;
        default: d = 8'hFF;
      endcase
      m = mk(d, 8'h30, 4'($urandom_range(0, 15)), 12'(i),
             {$urandom, $urandom}, {$urandom, $urandom});
      if (d == lid) res_q.push_back(exp_resp(m));
      else          byp_q.push_back(m);
      msgin = m;
      step();
      msgin = '0;
      step();
    end
    wait_idle();

    // credit limit, entry fill, drops
    okout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m = mk(8'h05, 8'h09, 4'(i % 5), 12'(16 + i),
             {$urandom, $urandom}, {$urandom, $urandom});
      if (i < 8) res_q.push_back(exp_resp(m));
      chk("okin_fill", MSG_W'(okin), MSG_W'(i < 8));
      msgin = m;
      step();
    end
    msgin = '0;
    repeat (4) step();
    chk("drop_cnt", MSG_W'(drop_cnt), MSG_W'(2));
    okout = 1'b1;
    wait_idle();

    // en stall of 5 cycles mid-flight
    m = mk(8'h05, 8'h09, 8'h4, 12'h777, 64'd6, 64'd7);
    res_q.push_back(exp_resp(m));
    lat_run(m, 1'b1, cyc);
    chk("lat_stall", MSG_W'(cyc), MSG_W'(9));
    wait_idle();

    // reset mid-stream discards everything
    okout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      msgin = mk((i == 3) ? 8'h22 : 8'h05, 8'h09, 4'h0, 12'(i), 64'd1, 64'd2);
      step();
    end
    msgin = '0;
    repeat (2) step();
    do_reset();

    // arbitration R,B,R,B with a frozen hold
    okout = 1'b0;
    m1 = mk(8'h05, 8'h09, 4'h1, 12'h101, 64'd50, 64'd8);
    b1 = mk(8'h22, 8'h09, 4'h0, 12'h201, 64'd1, 64'd1);
    m2 = mk(8'h05, 8'h09, 4'h3, 12'h102, 64'hF0, 64'h0F);
    b2 = mk(8'hFF, 8'h09, 4'h0, 12'h202, 64'd2, 64'd2);
    res_q.push_back(exp_resp(m1));
    byp_q.push_back(b1);
    res_q.push_back(exp_resp(m2));
    byp_q.push_back(b2);
    msgin = m1; step();
    msgin = b1; step();
    msgin = m2; step();
    msgin = b2; step();
    msgin = '0;
    repeat (8) step();
    kinds.delete();
    chk("hold_r", msgout, exp_resp(m1));
    okout = 1'b1;
    step();
    okout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_b", msgout, b1);
      step();
    end
    okout = 1'b1;
    wait_idle();
    ord = 4'hF;
    if (kinds.size() == 4) ord = {kinds[0], kinds[1], kinds[2], kinds[3]};
    chk("rr_order", MSG_W'(ord), MSG_W'(4'b0101));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
